// File: rtl/tmr_mon_pkg.sv
// Shared constants and helpers for the TMR error monitor.
// The helpers work on 32-bit values, so every width in the monitor must stay at or below 32 bits.
package tmr_mon_pkg;

    localparam int unsigned DEF_N_SRC       = 4;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_TOT_W       = 16;
    localparam int unsigned DEF_THRESHOLD   = 16;
    localparam int unsigned DEF_HOLD_CYCLES = 8;
    localparam int unsigned DEF_SEL_W       = 2;

    // Adds with a 33-bit intermediate and clamps the result to max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tmr_event_counter.sv
// Per-source rising-edge detector with saturating event counter and sticky flag.
module tmr_event_counter
    import tmr_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_err,
    output logic             o_ev,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sticky
);

    logic             r_err_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;
    logic             w_ev;

    assign w_ev     = i_err & ~r_err_q;
    assign o_ev     = w_ev;
    assign o_cnt    = r_cnt;
    assign o_sticky = r_sticky;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_q  <= 1'b0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_err_q <= i_err;
            // Clear reloads from the current event so a coincident edge is not lost.
            if (i_clear) begin
                r_cnt    <= {{(CNT_W-1){1'b0}}, w_ev};
                r_sticky <= w_ev;
            end else if (w_ev) begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmr_error_monitor.sv
// Collects voter tmrError levels, counts disagreement events and requests clock-gate refresh.
module tmr_error_monitor
    import tmr_mon_pkg::*;
#(
    parameter int unsigned N_SRC       = DEF_N_SRC,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TOT_W       = DEF_TOT_W,
    parameter int unsigned THRESHOLD   = DEF_THRESHOLD,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned SEL_W       = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] err_in,
    input  logic             clear,
    output logic             gate_req,
    output logic [N_SRC-1:0] sticky,
    output logic             thr_irq,
    output logic             thr_flag,
    output logic [TOT_W-1:0] total_cnt,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [31:0] TOT_MAX = 32'((33'd1 << TOT_W) - 33'd1);

    logic [N_SRC-1:0]  w_ev;
    logic [CNT_W-1:0]  w_cnt [N_SRC];
    logic              w_cross;
    logic [31:0]       w_pop;
    logic [TOT_W-1:0]  w_total_inc;
    logic [TOT_W-1:0]  w_total_clr;
    logic [CNT_W-1:0]  w_rd;

    logic [HOLD_W-1:0] r_hold;
    logic [TOT_W-1:0]  r_total;
    logic              r_irq;
    logic              r_flag;
    logic [CNT_W-1:0]  r_rd;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        tmr_event_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_clear (clear),
            .i_err   (err_in[gi]),
            .o_ev    (w_ev[gi]),
            .o_cnt   (w_cnt[gi]),
            .o_sticky(sticky[gi])
        );
    end

    always_comb begin
        w_cross = 1'b0;
        w_rd    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            // THRESHOLD <= max count, so a saturated counter can never re-cross.
            if (w_ev[i] && (w_cnt[i] == CNT_W'(THRESHOLD - 1))) begin
                w_cross = 1'b1;
            end
            if (32'(rd_sel) == 32'(i)) begin
                w_rd = w_cnt[i];
            end
        end
        w_pop       = popcount(32'(w_ev));
        w_total_inc = TOT_W'(sat_add(32'(r_total), w_pop, TOT_MAX));
        w_total_clr = TOT_W'(sat_add(32'd0, w_pop, TOT_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= '0;
            r_total <= '0;
            r_irq   <= 1'b0;
            r_flag  <= 1'b0;
            r_rd    <= '0;
        end else begin
            // The hold timer ignores clear: a refresh window always runs to completion.
            if (|w_ev) begin
                r_hold <= HOLD_W'(HOLD_CYCLES);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end

            if (clear) begin
                r_total <= w_total_clr;
                r_irq   <= 1'b0;
                r_flag  <= 1'b0;
            end else begin
                r_total <= w_total_inc;
                r_irq   <= w_cross;
                r_flag  <= r_flag | w_cross;
            end

            r_rd <= w_rd;
        end
    end

    assign gate_req  = (r_hold != '0);
    assign thr_irq   = r_irq;
    assign thr_flag  = r_flag;
    assign total_cnt = r_total;
    assign rd_cnt    = r_rd;

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Scoreboard bench: the driver pushes model predictions, a negedge monitor pops and compares.
module tb_tmr_error_monitor;

    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int TW   = 16;
    localparam int TH   = 16;
    localparam int HOLD = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  err_in = '0;
    logic          clear = 1'b0;
    logic [1:0]    rd_sel = '0;
    logic          gate_req;
    logic [N-1:0]  sticky;
    logic          thr_irq;
    logic          thr_flag;
    logic [TW-1:0] total_cnt;
    logic [CW-1:0] rd_cnt;

    tmr_error_monitor #(
        .N_SRC      (N),
        .CNT_W      (CW),
        .TOT_W      (TW),
        .THRESHOLD  (TH),
        .HOLD_CYCLES(HOLD),
        .SEL_W      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .err_in   (err_in),
        .clear    (clear),
        .gate_req (gate_req),
        .sticky   (sticky),
        .thr_irq  (thr_irq),
        .thr_flag (thr_flag),
        .total_cnt(total_cnt),
        .rd_sel   (rd_sel),
        .rd_cnt   (rd_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       due;
        bit       gate;
        bit [3:0] stk;
        bit       irq;
        bit       flag;
        int       total;
        int       rd;
    } exp_t;

    exp_t sb[$];
    int   total_checks = 0;
    int   bad = 0;
    bit   done = 1'b0;

    // Reference state: event history expressed as counts and the cycle of the last event.
    int       m_cnt [N];
    bit [3:0] m_prev;
    bit [3:0] m_stk;
    int       m_total;
    bit       m_flag;
    int       last_ev = -1000000;

    task automatic model();
        exp_t     x;
        bit [3:0] ev;
        int       pop;
        bit       irq;
        int       rd_v;
        irq  = 1'b0;
        rd_v = m_cnt[rd_sel];
        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_prev  = '0;
            m_stk   = '0;
            m_total = 0;
            m_flag  = 1'b0;
            last_ev = -1000000;
            rd_v    = 0;
        end else begin
            ev     = err_in & ~m_prev;
            m_prev = err_in;
            pop    = $countones(ev);
            for (int i = 0; i < N; i++) begin
                if (clear) begin
                    m_cnt[i] = ev[i] ? 1 : 0;
                end else if (ev[i]) begin
                    if (m_cnt[i] == TH - 1) irq = 1'b1;
                    m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                end
            end
            m_stk   = clear ? ev : (m_stk | ev);
            m_total = clear ? pop : ((m_total + pop > TMAX) ? TMAX : m_total + pop);
            m_flag  = clear ? 1'b0 : (m_flag | irq);
            if (ev != 0) last_ev = cyc;
        end
        x.due   = cyc + 1;
        x.gate  = (x.due - last_ev >= 1) && (x.due - last_ev <= HOLD);
        x.stk   = m_stk;
        x.irq   = irq;
        x.flag  = m_flag;
        x.total = m_total;
        x.rd    = rd_v;
        sb.push_back(x);
    endtask

    task automatic step(input logic [3:0] e, input bit c, input bit r, input logic [1:0] s);
        @(posedge clk);
        #1;
        err_in = e;
        clear  = c;
        rst    = r;
        rd_sel = s;
        model();
    endtask

    task automatic idle(input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b0, s);
    endtask

    task automatic pulses(input int src, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(4'(1 << src), 1'b0, 1'b0, 2'(src));
            idle(gap, 2'(src));
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total_checks++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, expv);
        end
    endtask

    // Monitor: compares DUT outputs on the falling edge against the queued predictions.
    initial begin
        exp_t e;
        int   wait_n;
        wait_n = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                total_checks++;
                bad++;
                $display("FAIL sb_late: entry due %0d unchecked at cycle %0d", e.due, cyc);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("gate_req", 32'(gate_req), 32'(e.gate));
                check("sticky", 32'(sticky), 32'(e.stk));
                check("thr_irq", 32'(thr_irq), 32'(e.irq));
                check("thr_flag", 32'(thr_flag), 32'(e.flag));
                check("total_cnt", 32'(total_cnt), 32'(e.total));
                check("rd_cnt", 32'(rd_cnt), 32'(e.rd));
            end
            if (done) begin
                if (sb.size() == 0) break;
                wait_n++;
                if (wait_n > 10) begin
                    total_checks++;
                    bad++;
                    $display("FAIL sb_drain: %0d entries left unchecked", sb.size());
                    break;
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

    // Driver
    initial begin
        logic [3:0] cur;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_prev = '0; m_stk = '0; m_total = 0; m_flag = 1'b0;

        step(4'b0000, 1'b0, 1'b1, 2'd0);
        step(4'b0000, 1'b0, 1'b1, 2'd0);
        idle(3, 2'd0);

        // Level held for 10 cycles counts once.
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b0, 1'b0, 2'd0);
        idle(12, 2'd0);

        // Repeated pulses on source 2 cross the threshold and keep the gate window open.
        pulses(2, 16, 2);
        idle(12, 2'd2);

        // All sources rise together.
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b0, 2'd1);
        for (int s = 0; s < N; s++) step(4'b0000, 1'b0, 1'b0, 2'(s));
        idle(8, 2'd3);

        // Counter saturation on source 1.
        step(4'b0000, 1'b0, 1'b1, 2'd1);
        pulses(1, 300, 1);
        idle(10, 2'd1);

        // Clear colliding with a rise on source 3.
        step(4'b0000, 1'b0, 1'b1, 2'd3);
        pulses(3, 5, 1);
        step(4'b1000, 1'b1, 1'b0, 2'd3);
        idle(4, 2'd3);

        // Reset during an active hold window with the level still high.
        step(4'b0000, 1'b0, 1'b1, 2'd0);
        pulses(0, 6, 1);
        step(4'b0001, 1'b0, 1'b0, 2'd0);
        step(4'b0001, 1'b0, 1'b0, 2'd0);
        step(4'b0001, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0, 2'd0);
        idle(10, 2'd0);

        // Random traffic with occasional clear and reset.
        cur = '0;
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) cur[b] = ~cur[b];
            end
            step(cur, ($urandom_range(0, 149) == 0), ($urandom_range(0, 499) == 0),
                 2'($urandom_range(0, 3)));
        end

        // Drive the total counter into saturation.
        step(4'b0000, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 16500; i++) begin
            step(4'b1111, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
            step(4'b0000, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        end
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        idle(12, 2'd2);

        done = 1'b1;
    end

endmodule
